uart_tx_fifo: RTL and testbench

Parametrised UART transmitter that generalises the existing single-byte, switch-driven transmitter. It accepts words over a valid/ready stream, buffers them in an internal FIFO and serialises them back-to-back as frames. Data width, baud divisor, parity mode, stop-bit count and FIFO depth are all configurable. It sits between any on-chip producer (debounced-button logic, a command sequencer or a CPU bus bridge) and the TxD pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit (and future receive) paths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Number of bit periods in one frame, start bit through last stop bit.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; push is ignored when full,
// pop is ignored when empty, and there is no write-to-read bypass.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   LVL_ONE    = 1;
    localparam logic [AW:0]   LVL_FULL   = DEPTH[AW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the cleared level makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready word input, FIFO, and a frame FSM that
// sends back-to-back frames on TxD with configurable width, parity and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          TxD,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_chk_par
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e           r_state;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [2:0]            r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_txd;
    logic                  r_busy;

    logic                  w_full;
    logic                  w_empty;
    logic [DATA_BITS-1:0]  w_head;
    logic                  w_pop;
    logic                  w_bit_done;
    logic                  w_par_bit;

    // NOTE: in_ready is gated by reset so no word can be accepted on the edge that clears the FIFO.
    assign in_ready   = !w_full && reset;
    assign w_bit_done = (r_clk_cnt == CNT_LAST);
    assign w_par_bit  = (^w_head) ^ (PARITY == PARITY_ODD);
    assign w_pop      = !w_empty &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_STOP && w_bit_done && r_bit_cnt == STOP_LAST));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid && in_ready),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_pop) begin
                r_shift   <= w_head;
                r_parity  <= w_par_bit;
                r_txd     <= 1'b0;
                r_busy    <= 1'b1;
                r_clk_cnt <= '0;
                r_bit_cnt <= '0;
                r_state   <= S_START;
            end
        end else if (!w_bit_done) begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
        end else begin
            r_clk_cnt <= '0;
            case (r_state)
                S_START: begin
                    r_txd     <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit_cnt == DATA_LAST) begin
                        r_bit_cnt <= '0;
                        if (PARITY != PARITY_NONE) begin
                            r_txd   <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                S_PARITY: begin
                    r_txd     <= 1'b1;
                    r_bit_cnt <= '0;
                    r_state   <= S_STOP;
                end
                S_STOP: begin
                    if (r_bit_cnt != STOP_LAST) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else if (w_pop) begin
                        // Next word starts immediately so frames stay contiguous.
                        r_shift   <= w_head;
                        r_parity  <= w_par_bit;
                        r_txd     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                    end else begin
                        r_txd     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TxD     = r_txd;
    assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations, line sampled every cycle
// and compared against frames built from a queue of pushed words.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 8N1, depth 4
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_txd, a_busy;
    logic [2:0] a_level;
    // E: 8E2, O: 8O2, depth 16
    logic [7:0] e_data, o_data;
    logic       e_valid, e_ready, e_txd, e_busy;
    logic       o_valid, o_ready, o_txd, o_busy;
    logic [4:0] e_level, o_level;
    // F: 5N1, depth 16
    logic [4:0] f_data;
    logic       f_valid, f_ready, f_txd, f_busy;
    logic [4:0] f_level;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .TxD(a_txd), .tx_busy(a_busy), .fifo_level(a_level));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_e (
        .clk(clk), .reset(reset), .in_data(e_data), .in_valid(e_valid), .in_ready(e_ready),
        .TxD(e_txd), .tx_busy(e_busy), .fifo_level(e_level));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_o (
        .clk(clk), .reset(reset), .in_data(o_data), .in_valid(o_valid), .in_ready(o_ready),
        .TxD(o_txd), .tx_busy(o_busy), .fifo_level(o_level));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_f (
        .clk(clk), .reset(reset), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .TxD(f_txd), .tx_busy(f_busy), .fifo_level(f_level));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle line samples of one frame; sample i sits at bit i.
    function automatic logic [63:0] expand(input logic [7:0] w, input int db, input int par,
                                           input int sb, input int cpb);
        logic [63:0] v;
        logic [15:0] bits;
        logic        p;
        int          nb;
        v    = '0;
        bits = '0;
        p    = 1'b0;
        for (int i = 0; i < db; i++) p = p ^ w[i];
        if (par == 2) p = ~p;
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < db; i++) begin
            bits[nb] = w[i];
            nb = nb + 1;
        end
        if (par != 0) begin
            bits[nb] = p;
            nb = nb + 1;
        end
        for (int i = 0; i < sb; i++) begin
            bits[nb] = 1'b1;
            nb = nb + 1;
        end
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < cpb; j++)
                v[i*cpb + j] = bits[i];
        return v;
    endfunction

    // Scoreboard for instance A: words pushed at accept time, popped when a frame completes.
    logic [7:0] q_a[$];
    int         a_frames;
    int         a_starts;
    int         a_start_cyc[$];

    initial begin : mon_a
        logic [63:0] cap;
        logic [7:0]  w;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && a_txd === 1'b0) begin
                a_starts++;
                a_start_cyc.push_back(cyc);
                cap     = '0;
                cap[0]  = a_txd;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) aborted = 1'b1;
                    cap[i] = a_txd;
                end
                if (!aborted) begin
                    check("a_frame_expected", 64'(q_a.size() != 0), 64'd1);
                    if (q_a.size() != 0) begin
                        w = q_a.pop_front();
                        check("a_frame", cap, expand(w, 8, 0, 1, 4));
                    end
                    a_frames++;
                end
            end
        end
    end

    initial begin : main
        logic [7:0]  q_e[$];
        logic [7:0]  q_o[$];
        logic [7:0]  burst [3];
        logic [7:0]  w6 [6];
        logic [63:0] cap_e, cap_o, cap_f;
        int          t, idx, busy_cnt, starts0, frames0;
        bit          saw_full;

        burst = '{8'h22, 8'h3C, 8'hC4};
        w6    = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h5A};
        reset = 1'b0;
        a_data = '0; a_valid = 1'b0;
        e_data = '0; e_valid = 1'b0;
        o_data = '0; o_valid = 1'b0;
        f_data = '0; f_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", a_txd, 1);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 0);
        check("rst_level", a_level, 0);
        check("rst_txd_eof", {e_txd, o_txd, f_txd}, 3'b111);
        reset = 1'b1;
        #1;
        check("ready_after_rst", a_ready, 1);

        // 8N1 0xA5: one cycle from accept to start bit, 40 busy cycles
        @(negedge clk);
        a_data = 8'hA5; a_valid = 1'b1; q_a.push_back(8'hA5);
        @(negedge clk);
        a_valid = 1'b0; a_data = 8'hFF;
        check("a5_level_after_push", a_level, 1);
        check("a5_txd_before_pop", a_txd, 1);
        @(negedge clk);
        check("a5_start_bit", a_txd, 0);
        check("a5_busy_rise", a_busy, 1);
        check("a5_level_after_pop", a_level, 0);
        busy_cnt = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_busy) busy_cnt++;
        end
        check("a5_busy_cycles", busy_cnt, 40);
        check("a5_frame_count", a_frames, 1);

        // Burst of 3 while a frame is running: level 1,2,3 and contiguous frames
        a_start_cyc.delete();
        @(negedge clk);
        a_data = 8'h11; a_valid = 1'b1; q_a.push_back(8'h11);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) check("burst_level", a_level, k);
            check("burst_ready", a_ready, 1);
            a_data = burst[k]; a_valid = 1'b1; q_a.push_back(burst[k]);
        end
        @(negedge clk);
        check("burst_level", a_level, 3);
        a_valid = 1'b0; a_data = 8'h00;
        for (int lv = 2; lv >= 0; lv--) begin
            t = 0;
            while (a_level != 3'(lv) && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("burst_level_dec", a_level, lv);
        end
        t = 0;
        while (a_busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("burst_drain", a_busy, 0);
        check("burst_starts", a_start_cyc.size(), 4);
        for (int k = 1; k < 4 && k < a_start_cyc.size(); k++)
            check("burst_gap", a_start_cyc[k] - a_start_cyc[k-1], 40);
        check("burst_frame_count", a_frames, 5);

        // Depth 4 with 6 words under continuous in_valid
        a_start_cyc.delete();
        idx = 0; t = 0; saw_full = 1'b0;
        while (idx < 6 && t < 1000) begin
            @(negedge clk);
            t++;
            a_valid = 1'b1; a_data = w6[idx];
            check("full_ready_vs_level", a_ready, a_level != 3'd4);
            if (!a_ready) saw_full = 1'b1;
            if (a_ready) begin
                q_a.push_back(w6[idx]);
                idx++;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        check("full_all_accepted", idx, 6);
        check("full_reached", saw_full, 1);
        t = 0;
        while ((a_busy || a_level != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("full_drain", a_busy, 0);
        check("full_frame_count", a_frames, 11);
        check("full_starts", a_start_cyc.size(), 6);
        check("full_queue_empty", q_a.size(), 0);

        // Reset during DATA of a frame with two words queued
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_data = 8'h5A + 8'(k); a_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_level_before", a_level, 2);
        check("abort_busy_before", a_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_txd", a_txd, 1);
        check("abort_level", a_level, 0);
        check("abort_busy", a_busy, 0);
        check("abort_ready", a_ready, 0);
        reset = 1'b1;
        q_a.delete();
        starts0 = a_starts;
        frames0 = a_frames;
        repeat (80) @(negedge clk);
        check("abort_no_frames", a_starts, starts0);
        check("abort_idle_txd", a_txd, 1);
        @(negedge clk);
        a_data = 8'h96; a_valid = 1'b1; q_a.push_back(8'h96);
        @(negedge clk);
        a_valid = 1'b0;
        t = 0;
        while (a_frames == frames0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort_new_frame", a_frames, frames0 + 1);
        check("abort_queue_empty", q_a.size(), 0);

        // Even and odd parity with two stop bits, data 0x07
        @(negedge clk);
        e_data = 8'h07; e_valid = 1'b1; q_e.push_back(8'h07);
        o_data = 8'h07; o_valid = 1'b1; q_o.push_back(8'h07);
        @(negedge clk);
        e_valid = 1'b0; o_valid = 1'b0;
        t = 0;
        while (e_txd !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("par_start_seen", e_txd, 0);
        cap_e = '0; cap_o = '0;
        cap_e[0] = e_txd; cap_o[0] = o_txd;
        for (int i = 1; i < 48; i++) begin
            @(negedge clk);
            cap_e[i] = e_txd; cap_o[i] = o_txd;
        end
        check("par_busy_last", {e_busy, o_busy}, 2'b11);
        @(negedge clk);
        check("par_busy_fall", {e_busy, o_busy}, 2'b00);
        check("par_idle_txd", {e_txd, o_txd}, 2'b11);
        check("even_parity_bit", cap_e[38], 1);
        check("odd_parity_bit", cap_o[38], 0);
        check("even_frame", cap_e, expand(q_e.pop_front(), 8, 1, 2, 4));
        check("odd_frame", cap_o, expand(q_o.pop_front(), 8, 2, 2, 4));

        // Five data bits, 7-bit frame
        @(negedge clk);
        f_data = 5'h1F; f_valid = 1'b1;
        @(negedge clk);
        f_valid = 1'b0; f_data = 5'h00;
        @(negedge clk);
        cap_f = '0;
        cap_f[0] = f_txd;
        for (int i = 1; i < 28; i++) begin
            @(negedge clk);
            cap_f[i] = f_txd;
        end
        check("d5_busy_last", f_busy, 1);
        @(negedge clk);
        check("d5_busy_fall", f_busy, 0);
        check("d5_frame", cap_f, expand(8'h1F, 5, 0, 1, 4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
